// File: rtl/icache_pkg.sv
// ---------------------------------------------------------------------------
// icache_pkg: shared defaults, field widths and types for the I-cache. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package icache_pkg;

  localparam int          DEF_LINES      = 64;
  localparam int          DEF_WORDS      = 4;
  localparam logic [31:0] DEF_TEXT_BASE  = 32'h0000_0000;
  localparam logic [31:0] DEF_TEXT_LIMIT = 32'h0001_0000;

  localparam int OFF_W = $clog2(DEF_WORDS);
  localparam int IDX_W = $clog2(DEF_LINES);
  localparam int TAG_W = 32 - 2 - OFF_W - IDX_W;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] index;
    logic [OFF_W-1:0] offset;
    logic [1:0]       byte_sel;
  } icache_addr_t;

endpackage

`default_nettype wire

// File: rtl/icache_fill_fsm.sv
// ---------------------------------------------------------------------------
// icache_fill_fsm: single-outstanding line refill sequencer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module icache_fill_fsm
  import icache_pkg::*;
#(
  parameter int WORDS = DEF_WORDS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [31:0]   start_base,
  input  logic          mem_valid,
  input  logic          inv,
  output icache_state_t state,
  output logic [31:0]   mem_addr,
  output logic          mem_rd,
  output logic          busy,
  output logic          discard,
  output logic          fill_we,
  output logic          fill_last
);

  localparam int CNT_W = $clog2(WORDS);

  icache_state_t    state_nxt;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fill_we   = 1'b0;
    fill_last = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FILL;
      end
      FILL: begin
        fill_we   = mem_valid;
        fill_last = mem_valid && (cnt == CNT_W'(WORDS - 1));
        if (fill_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      busy     <= 1'b0;
      discard  <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        cnt      <= '0;
        mem_addr <= start_base;
        mem_rd   <= 1'b1;
        busy     <= 1'b1;
      end else if (fill_we) begin
        cnt      <= cnt + CNT_W'(1);
        mem_addr <= mem_addr + 32'd4;
        if (fill_last) begin
          mem_rd <= 1'b0;
          busy   <= 1'b0;
        end
      end
      // An invalidate mid-fill must outlive the current beat so the line
      // is not marked valid at completion.
      if (state == FILL) begin
        if (fill_last) discard <= 1'b0;
        else if (inv)  discard <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/icache_resp.sv
// ---------------------------------------------------------------------------
// icache_resp: direct-mapped I-cache with 1-cycle fetch response. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module icache_resp
  import icache_pkg::*;
#(
  parameter int          LINES      = DEF_LINES,
  parameter int          WORDS      = DEF_WORDS,
  parameter logic [31:0] TEXT_BASE  = DEF_TEXT_BASE,
  parameter logic [31:0] TEXT_LIMIT = DEF_TEXT_LIMIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_addr,
  input  logic        i_rd,
  input  logic        stall,
  input  logic        inv,
  output logic [31:0] i_data,
  output logic        i_miss,
  output logic        i_segfault,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid,
  output logic        busy
);

  localparam int OFF_BITS = $clog2(WORDS);
  localparam int IDX_BITS = $clog2(LINES);
  localparam int LO_BITS  = 2 + OFF_BITS;
  localparam int TAG_BITS = 32 - LO_BITS - IDX_BITS;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tag_mem  [0:LINES-1];
  logic [31:0]         data_mem [0:LINES*WORDS-1];

  logic [TAG_BITS-1:0] req_tag;
  logic [IDX_BITS-1:0] req_idx;
  logic [OFF_BITS-1:0] req_off;
  logic                seg;
  logic                hit;
  logic                lookup;
  logic                start;
  logic [31:0]         start_base;

  icache_state_t       state;
  logic                discard;
  logic                fill_we;
  logic                fill_last;
  logic [TAG_BITS-1:0] fill_tag;
  logic [IDX_BITS-1:0] fill_idx;
  logic [OFF_BITS-1:0] fill_off;

  assign req_tag = i_addr[31 -: TAG_BITS];
  assign req_idx = i_addr[LO_BITS +: IDX_BITS];
  assign req_off = i_addr[2 +: OFF_BITS];

  // Single unsigned window test; addresses below the base wrap to huge offsets.
  assign seg = ((i_addr - TEXT_BASE) >= (TEXT_LIMIT - TEXT_BASE)) || (i_addr[1:0] != 2'b00);
  assign hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);

  assign lookup     = i_rd && !stall;
  assign start      = lookup && !seg && !hit && (state == IDLE);
  assign start_base = {i_addr[31:LO_BITS], {LO_BITS{1'b0}}};

  // mem_addr stays within the line until the beat after the last word.
  assign fill_tag = mem_addr[31 -: TAG_BITS];
  assign fill_idx = mem_addr[LO_BITS +: IDX_BITS];
  assign fill_off = mem_addr[2 +: OFF_BITS];

  icache_fill_fsm #(
    .WORDS (WORDS)
  ) u_fill (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_base (start_base),
    .mem_valid  (mem_valid),
    .inv        (inv),
    .state      (state),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .busy       (busy),
    .discard    (discard),
    .fill_we    (fill_we),
    .fill_last  (fill_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (inv) begin
      valid <= '0;
    end else begin
      if (start)                 valid[req_idx]  <= 1'b0;
      if (fill_last && !discard) valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we)   data_mem[{fill_idx, fill_off}] <= mem_rdata;
    if (fill_last) tag_mem[fill_idx]              <= fill_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_data     <= '0;
      i_miss     <= 1'b0;
      i_segfault <= 1'b0;
    end else if (!stall) begin
      i_data     <= '0;
      i_miss     <= 1'b0;
      i_segfault <= 1'b0;
      if (i_rd) begin
        if (seg)      i_segfault <= 1'b1;
        else if (hit) i_data     <= data_mem[{req_idx, req_off}];
        else          i_miss     <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_icache_resp.sv
// ---------------------------------------------------------------------------
// tb_icache_resp: directed vector bench for icache_resp. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_icache_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_addr;
  logic        i_rd;
  logic        stall;
  logic        inv;
  logic [31:0] i_data;
  logic        i_miss;
  logic        i_segfault;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  icache_resp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_addr     (i_addr),
    .i_rd       (i_rd),
    .stall      (stall),
    .inv        (inv),
    .i_data     (i_data),
    .i_miss     (i_miss),
    .i_segfault (i_segfault),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .mem_valid  (mem_valid),
    .busy       (busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic        rd, stl, iv, mv;
    logic [31:0] rdata;
    logic [31:0] e_data;
    logic        e_miss, e_seg, e_mrd, e_busy, chk_addr;
    logic [31:0] e_maddr;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] addr, input logic rd, stl, iv, mv,
                              input logic [31:0] rdata, input logic [31:0] e_data,
                              input logic e_miss, e_seg, e_mrd, e_busy, chk_addr,
                              input logic [31:0] e_maddr);
    vec_t v;
    v.addr = addr; v.rd = rd; v.stl = stl; v.iv = iv; v.mv = mv; v.rdata = rdata;
    v.e_data = e_data; v.e_miss = e_miss; v.e_seg = e_seg; v.e_mrd = e_mrd;
    v.e_busy = e_busy; v.chk_addr = chk_addr; v.e_maddr = e_maddr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input string tag);
    i_addr    = v.addr;
    i_rd      = v.rd;
    stall     = v.stl;
    inv       = v.iv;
    mem_valid = v.mv;
    mem_rdata = v.rdata;
    step();
    chk({tag, " i_data"},     i_data,     v.e_data);
    chk({tag, " i_miss"},     32'(i_miss),     32'(v.e_miss));
    chk({tag, " i_segfault"}, 32'(i_segfault), 32'(v.e_seg));
    chk({tag, " mem_rd"},     32'(mem_rd),     32'(v.e_mrd));
    chk({tag, " busy"},       32'(busy),       32'(v.e_busy));
    if (v.chk_addr) chk({tag, " mem_addr"}, mem_addr, v.e_maddr);
  endtask

  vec_t tbl[$];

  initial begin
    // Cold miss and 4-word refill of 0x100, then a hit on the new line.
    tbl.push_back(mk(32'h100, 1,0,0,0, 32'h0,  32'h0,  1,0, 1,1, 1, 32'h100));
    tbl.push_back(mk(32'h0,   0,0,0,1, 32'h11, 32'h0,  0,0, 1,1, 1, 32'h104));
    tbl.push_back(mk(32'h0,   0,0,0,1, 32'h22, 32'h0,  0,0, 1,1, 1, 32'h108));
    tbl.push_back(mk(32'h0,   0,0,0,1, 32'h33, 32'h0,  0,0, 1,1, 1, 32'h10C));
    tbl.push_back(mk(32'h0,   0,0,0,1, 32'h44, 32'h0,  0,0, 0,0, 0, 32'h0));
    tbl.push_back(mk(32'h108, 1,0,0,0, 32'h0,  32'h33, 0,0, 0,0, 0, 32'h0));
    // Segfaults: first address past the limit, then a misaligned PC.
    tbl.push_back(mk(32'h1_0000, 1,0,0,0, 32'h0, 32'h0, 0,1, 0,0, 0, 32'h0));
    tbl.push_back(mk(32'h102,    1,0,0,0, 32'h0, 32'h0, 0,1, 0,0, 0, 32'h0));
    // Hit-under-miss while 0x200 fills; the 0x300 miss is not queued.
    tbl.push_back(mk(32'h200, 1,0,0,0, 32'h0,  32'h0,  1,0, 1,1, 1, 32'h200));
    tbl.push_back(mk(32'h104, 1,0,0,0, 32'h0,  32'h22, 0,0, 1,1, 1, 32'h200));
    tbl.push_back(mk(32'h300, 1,0,0,0, 32'h0,  32'h0,  1,0, 1,1, 1, 32'h200));
    tbl.push_back(mk(32'h0,   0,0,0,0, 32'h0,  32'h0,  0,0, 1,1, 1, 32'h200));
    tbl.push_back(mk(32'h0,   0,0,0,1, 32'hA0, 32'h0,  0,0, 1,1, 1, 32'h204));
    tbl.push_back(mk(32'h0,   0,0,0,1, 32'hA1, 32'h0,  0,0, 1,1, 1, 32'h208));
    tbl.push_back(mk(32'h0,   0,0,0,1, 32'hA2, 32'h0,  0,0, 1,1, 1, 32'h20C));
    // Last beat coincides with a fresh miss: reported, no new fill.
    tbl.push_back(mk(32'h300, 1,0,0,1, 32'hA3, 32'h0,  1,0, 0,0, 0, 32'h0));
    tbl.push_back(mk(32'h0,   0,0,0,0, 32'h0,  32'h0,  0,0, 0,0, 0, 32'h0));
    tbl.push_back(mk(32'h20C, 1,0,0,0, 32'h0,  32'hA3, 0,0, 0,0, 0, 32'h0));
    // Stall holds the response; a stalled miss must not start a fill.
    tbl.push_back(mk(32'h100, 1,0,0,0, 32'h0,  32'h11, 0,0, 0,0, 0, 32'h0));
    tbl.push_back(mk(32'h104, 1,1,0,0, 32'h0,  32'h11, 0,0, 0,0, 0, 32'h0));
    tbl.push_back(mk(32'h108, 1,1,0,0, 32'h0,  32'h11, 0,0, 0,0, 0, 32'h0));
    tbl.push_back(mk(32'h400, 1,1,0,0, 32'h0,  32'h11, 0,0, 0,0, 0, 32'h0));
    tbl.push_back(mk(32'h10C, 1,0,0,0, 32'h0,  32'h44, 0,0, 0,0, 0, 32'h0));

    rst_n = 1'b0; i_addr = '0; i_rd = 1'b0; stall = 1'b0; inv = 1'b0;
    mem_valid = 1'b0; mem_rdata = '0;
    step(); step();
    chk("reset i_data",     i_data,                '0);
    chk("reset i_miss",     32'(i_miss),           '0);
    chk("reset i_segfault", 32'(i_segfault),       '0);
    chk("reset mem_rd",     32'(mem_rd),           '0);
    chk("reset mem_addr",   mem_addr,              '0);
    chk("reset busy",       32'(busy),             '0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("v%0d", i));

    // inv during the 2nd word of a 0x700 fill: line stays invalid, and so do residents.
    apply(mk(32'h700, 1,0,0,0, 32'h0,  32'h0, 1,0, 1,1, 1, 32'h700), "inv start");
    apply(mk(32'h0,   0,0,0,1, 32'h71, 32'h0, 0,0, 1,1, 1, 32'h704), "inv w0");
    apply(mk(32'h0,   0,0,1,1, 32'h72, 32'h0, 0,0, 1,1, 1, 32'h708), "inv w1");
    apply(mk(32'h0,   0,0,0,1, 32'h73, 32'h0, 0,0, 1,1, 1, 32'h70C), "inv w2");
    apply(mk(32'h0,   0,0,0,1, 32'h74, 32'h0, 0,0, 0,0, 0, 32'h0),   "inv w3");
    apply(mk(32'h700, 1,0,0,0, 32'h0,  32'h0, 1,0, 1,1, 1, 32'h700), "inv refetch");
    apply(mk(32'h100, 1,0,0,0, 32'h0,  32'h0, 1,0, 1,1, 1, 32'h700), "inv old100");
    apply(mk(32'h200, 1,0,0,0, 32'h0,  32'h0, 1,0, 1,1, 1, 32'h700), "inv old200");

    // Reset after two words of the refetch fill, with mem_valid still asserted.
    apply(mk(32'h0, 0,0,0,1, 32'h81, 32'h0, 0,0, 1,1, 1, 32'h704), "rst w0");
    apply(mk(32'h0, 0,0,0,1, 32'h82, 32'h0, 0,0, 1,1, 1, 32'h708), "rst w1");
    rst_n = 1'b0;
    #1;
    chk("midreset mem_rd",   32'(mem_rd), '0);
    chk("midreset busy",     32'(busy),   '0);
    chk("midreset mem_addr", mem_addr,    '0);
    step();
    rst_n = 1'b1;
    apply(mk(32'h0,   0,0,0,1, 32'h83, 32'h0, 0,0, 0,0, 1, 32'h0),   "rst stray mv");
    apply(mk(32'h100, 1,0,0,0, 32'h0,  32'h0, 1,0, 1,1, 1, 32'h100), "rst refill");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
